gf_log_gen: RTL

//  Run-time GF(2^M) log/antilog table generator and lookup engine.
//  - Builds both tables in internal RAM by walking alpha^i for a programmable

---
 rtl/gf_log_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/gf_log_gen.sv
// GF(2^M) log/antilog table generator: walks alpha^i for a run-time polynomial,
// fills both tables, then serves single-cycle-latency lookups.
module gf_log_gen #(
    parameter int         M            = 8,
    parameter logic [M:0] POLY_DEFAULT = 9'h11D
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [M:0]   poly_i,
    input  logic         init_i,
    output logic         busy_o,
    output logic         ready_o,
    output logic         err_o,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_mode_i,
    input  logic [M-1:0] req_addr_i,
    output logic         rsp_valid_o,
    output logic [M-1:0] rsp_data_o,
    output logic         rsp_zero_o
);
    // state | meaning
    // BUILD | writing alog[i]=alpha^i and log[alpha^i]=i, i = 0..2^M-2
    // READY | tables valid, lookups accepted, init_i starts a rebuild
    // ERROR | polynomial rejected or not primitive, tables stale

    localparam int           N        = 2 ** M;
    localparam logic [M-1:0] LAST_IDX = M'(N - 2);
    localparam logic [M-1:0] ONE      = M'(1);
    localparam logic [M-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {BUILD, READY, ERROR} state_t;

    state_t       state;
    logic [M-1:0] poly_q;
    logic [M-1:0] cnt;
    logic [M-1:0] elem;
    logic [M-1:0] elem_next;
    logic         accept;
    logic [M-1:0] alog_idx;

    logic [M-1:0] alog_mem [N];
    logic [M-1:0] log_mem  [N];

    assign elem_next   = {elem[M-2:0], 1'b0} ^ (elem[M-1] ? poly_q : '0);
    assign req_ready_o = ready_o;
    assign accept      = req_valid_i && ready_o;
    // alpha^(2^M-1) == alpha^0, and alog[2^M-1] is never written
    assign alog_idx    = (req_addr_i == ALL_ONES) ? '0 : req_addr_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= BUILD;
            poly_q  <= POLY_DEFAULT[M-1:0];
            cnt     <= '0;
            elem    <= ONE;
            busy_o  <= 1'b1;
            ready_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            case (state)
                BUILD: begin
                    // completion wins: for a primitive polynomial the last step also returns to 1
                    if (cnt == LAST_IDX) begin
                        state   <= READY;
                        busy_o  <= 1'b0;
                        ready_o <= 1'b1;
                    end else if (elem_next == ONE) begin
                        state  <= ERROR;
                        busy_o <= 1'b0;
                        err_o  <= 1'b1;
                    end else begin
                        cnt  <= cnt + ONE;
                        elem <= elem_next;
                    end
                end
                READY, ERROR: begin
                    if (init_i) begin
                        if (!poly_i[M] || !poly_i[0]) begin
                            state   <= ERROR;
                            busy_o  <= 1'b0;
                            ready_o <= 1'b0;
                            err_o   <= 1'b1;
                        end else begin
                            state   <= BUILD;
                            poly_q  <= poly_i[M-1:0];
                            cnt     <= '0;
                            elem    <= ONE;
                            busy_o  <= 1'b1;
                            ready_o <= 1'b0;
                            err_o   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ERROR;
                    busy_o  <= 1'b0;
                    ready_o <= 1'b0;
                    err_o   <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == BUILD) begin
            alog_mem[cnt] <= elem;
            log_mem[elem] <= cnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_zero_o  <= 1'b0;
        end else begin
            rsp_valid_o <= accept;
            if (accept) begin
                if (req_mode_i) begin
                    rsp_data_o <= alog_mem[alog_idx];
                    rsp_zero_o <= 1'b0;
                end else if (req_addr_i == '0) begin
                    rsp_data_o <= '0;
                    rsp_zero_o <= 1'b1;
                end else begin
                    rsp_data_o <= log_mem[req_addr_i];
                    rsp_zero_o <= 1'b0;
                end
            end
        end
    end

endmodule
